// File: rtl/dmmu_xlate_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmmu_xlate_if
//  Description : Request/response handshake bundle between the EX/MEM load-
//                store path and the data-side address-translation stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dmmu_xlate_if #(
    parameter int TLBNUM = 16
);
    localparam int IDXW = $clog2(TLBNUM);

    // Request from EX
    logic            req_valid;
    logic            req_ready;
    logic [31:0]     req_va;
    logic            req_wr;

    // Response to MEM
    logic            resp_valid;
    logic            resp_ready;
    logic [31:0]     resp_pa;
    logic [1:0]      resp_mat;
    logic            resp_exc;
    logic [5:0]      resp_ecode;
    logic [31:0]     resp_badv;
    logic [IDXW-1:0] resp_tlb_index;

    modport master (
        output req_valid, req_va, req_wr, resp_ready,
        input  req_ready, resp_valid, resp_pa, resp_mat, resp_exc,
               resp_ecode, resp_badv, resp_tlb_index
    );

    modport slave (
        input  req_valid, req_va, req_wr, resp_ready,
        output req_ready, resp_valid, resp_pa, resp_mat, resp_exc,
               resp_ecode, resp_badv, resp_tlb_index
    );
endinterface
`default_nettype wire

// File: rtl/dmmu_xlate.sv
`default_nettype none
// ============================================================================
//  Module      : dmmu_xlate
//  Description : Two-stage load/store address translation (DA / DMW / TLB)
//                in front of the data cache. Stage 1 holds the request and
//                drives TLB search port 1; stage 2 is the registered result.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmmu_xlate #(
    parameter int TLBNUM = 16
) (
    input  wire logic                      clk,
    input  wire logic                      reset,
    input  wire logic                      flush,
    dmmu_xlate_if.slave                    bus,
    input  wire logic                      csr_da,
    input  wire logic                      csr_pg,
    input  wire logic [1:0]                csr_plv,
    input  wire logic [1:0]                csr_datm,
    input  wire logic [9:0]                csr_asid,
    input  wire logic [31:0]               csr_dmw0,
    input  wire logic [31:0]               csr_dmw1,
    output      logic [18:0]               s1_vppn,
    output      logic                      s1_va_bit12,
    output      logic [9:0]                s1_asid,
    input  wire logic                      s1_found,
    input  wire logic [$clog2(TLBNUM)-1:0] s1_index,
    input  wire logic [19:0]               s1_ppn,
    input  wire logic [5:0]                s1_ps,
    input  wire logic [1:0]                s1_plv,
    input  wire logic [1:0]                s1_mat,
    input  wire logic                      s1_d,
    input  wire logic                      s1_v
);
    localparam int IDXW = $clog2(TLBNUM);

    localparam logic [5:0] C_ECODE_PIL  = 6'h01;
    localparam logic [5:0] C_ECODE_PIS  = 6'h02;
    localparam logic [5:0] C_ECODE_PME  = 6'h04;
    localparam logic [5:0] C_ECODE_PPI  = 6'h07;
    localparam logic [5:0] C_ECODE_TLBR = 6'h3F;

    // Request snapshot: CSRs are frozen at accept so later writes cannot
    // change the translation of a request already in flight.
    typedef struct packed {
        logic [31:0] va;
        logic        wr;
        logic        da;
        logic        pg;
        logic [1:0]  plv;
        logic [1:0]  datm;
        logic [9:0]  asid;
        logic [31:0] dmw0;
        logic [31:0] dmw1;
    } stage1_t;

    typedef struct packed {
        logic [31:0]     pa;
        logic [1:0]      mat;
        logic            exc;
        logic [5:0]      ecode;
        logic [31:0]     badv;
        logic [IDXW-1:0] idx;
    } stage2_t;

    stage1_t stage1_q, stage1_d;
    stage2_t stage2_q, stage2_d;
    logic    stage1_vld_q, stage1_vld_d;
    logic    stage2_vld_q, stage2_vld_d;

    logic        w_s2_free;
    logic        w_advance;
    logic        w_accept;
    logic        w_dmw0_hit;
    logic        w_dmw1_hit;
    logic [31:0] w_pa;
    logic [1:0]  w_mat;
    logic        w_exc;
    logic [5:0]  w_ecode;

    assign w_s2_free     = !stage2_vld_q || bus.resp_ready;
    assign w_advance     = stage1_vld_q && w_s2_free;
    assign bus.req_ready = !stage1_vld_q || w_s2_free;
    assign w_accept      = bus.req_valid && bus.req_ready && !flush;

    // TLB search key comes straight from the stage-1 snapshot, quiet when idle
    assign s1_vppn     = stage1_vld_q ? stage1_q.va[31:13] : 19'd0;
    assign s1_va_bit12 = stage1_vld_q ? stage1_q.va[12]    : 1'b0;
    assign s1_asid     = stage1_vld_q ? stage1_q.asid      : 10'd0;

    // pg is kept in the snapshot for completeness; paging is assumed whenever
    // DA is clear, so pg and the reserved DMW fields never steer the result.
    logic unused_bits;
    assign unused_bits = ^{stage1_q.pg, stage1_q.dmw0[28], stage1_q.dmw0[24:6],
                           stage1_q.dmw0[2:1], stage1_q.dmw1[28],
                           stage1_q.dmw1[24:6], stage1_q.dmw1[2:1]};

    // Translate the stage-1 request: DA, then DMW0, DMW1, then TLB checks
    always_comb begin
        w_pa    = 32'd0;
        w_mat   = 2'd0;
        w_exc   = 1'b0;
        w_ecode = 6'd0;
        w_dmw0_hit = ((stage1_q.plv == 2'd0 && stage1_q.dmw0[0]) ||
                      (stage1_q.plv == 2'd3 && stage1_q.dmw0[3])) &&
                     (stage1_q.va[31:29] == stage1_q.dmw0[31:29]);
        w_dmw1_hit = ((stage1_q.plv == 2'd0 && stage1_q.dmw1[0]) ||
                      (stage1_q.plv == 2'd3 && stage1_q.dmw1[3])) &&
                     (stage1_q.va[31:29] == stage1_q.dmw1[31:29]);
        if (stage1_q.da) begin
            w_pa  = stage1_q.va;
            w_mat = stage1_q.datm;
        end else if (w_dmw0_hit) begin
            w_pa  = {stage1_q.dmw0[27:25], stage1_q.va[28:0]};
            w_mat = stage1_q.dmw0[5:4];
        end else if (w_dmw1_hit) begin
            w_pa  = {stage1_q.dmw1[27:25], stage1_q.va[28:0]};
            w_mat = stage1_q.dmw1[5:4];
        end else if (!s1_found) begin
            w_exc   = 1'b1;
            w_ecode = C_ECODE_TLBR;
        end else if (!s1_v) begin
            w_exc   = 1'b1;
            w_ecode = stage1_q.wr ? C_ECODE_PIS : C_ECODE_PIL;
        end else if (stage1_q.plv > s1_plv) begin
            w_exc   = 1'b1;
            w_ecode = C_ECODE_PPI;
        end else if (stage1_q.wr && !s1_d) begin
            w_exc   = 1'b1;
            w_ecode = C_ECODE_PME;
        end else begin
            w_mat = s1_mat;
            // Page sizes other than 4M are handled as 4K pages
            if (s1_ps == 6'd21) begin
                w_pa = {s1_ppn[19:9], stage1_q.va[20:0]};
            end else begin
                w_pa = {s1_ppn, stage1_q.va[11:0]};
            end
        end
    end

    // Pipeline next state: accept into S1, move S1 to S2, drain S2; flush wins
    always_comb begin
        stage1_vld_d = stage1_vld_q;
        stage1_d     = stage1_q;
        stage2_vld_d = stage2_vld_q;
        stage2_d     = stage2_q;
        if (w_advance) begin
            stage1_vld_d   = 1'b0;
            stage2_vld_d   = 1'b1;
            stage2_d.pa    = w_pa;
            stage2_d.mat   = w_mat;
            stage2_d.exc   = w_exc;
            stage2_d.ecode = w_ecode;
            stage2_d.badv  = stage1_q.va;
            stage2_d.idx   = s1_index;
        end else if (w_s2_free) begin
            stage2_vld_d = 1'b0;
        end
        if (w_accept) begin
            stage1_vld_d  = 1'b1;
            stage1_d.va   = bus.req_va;
            stage1_d.wr   = bus.req_wr;
            stage1_d.da   = csr_da;
            stage1_d.pg   = csr_pg;
            stage1_d.plv  = csr_plv;
            stage1_d.datm = csr_datm;
            stage1_d.asid = csr_asid;
            stage1_d.dmw0 = csr_dmw0;
            stage1_d.dmw1 = csr_dmw1;
        end
        if (flush) begin
            stage1_vld_d = 1'b0;
            stage2_vld_d = 1'b0;
        end
    end

    // Stage registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            stage1_vld_q <= 1'b0;
            stage2_vld_q <= 1'b0;
            stage1_q     <= '0;
            stage2_q     <= '0;
        end else begin
            stage1_vld_q <= stage1_vld_d;
            stage2_vld_q <= stage2_vld_d;
            stage1_q     <= stage1_d;
            stage2_q     <= stage2_d;
        end
    end

    assign bus.resp_valid     = stage2_vld_q;
    assign bus.resp_pa        = stage2_q.pa;
    assign bus.resp_mat       = stage2_q.mat;
    assign bus.resp_exc       = stage2_q.exc;
    assign bus.resp_ecode     = stage2_q.ecode;
    assign bus.resp_badv      = stage2_q.badv;
    assign bus.resp_tlb_index = stage2_q.idx;
endmodule
`default_nettype wire

// File: tb/tb_dmmu_xlate.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmmu_xlate
//  Description : Directed scoreboard bench for dmmu_xlate.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmmu_xlate;
    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        csr_da, csr_pg;
    logic [1:0]  csr_plv, csr_datm;
    logic [9:0]  csr_asid;
    logic [31:0] csr_dmw0, csr_dmw1;
    logic [18:0] s1_vppn;
    logic        s1_va_bit12;
    logic [9:0]  s1_asid;
    logic        tlb_found, tlb_d, tlb_v;
    logic [3:0]  tlb_index;
    logic [19:0] tlb_ppn;
    logic [5:0]  tlb_ps;
    logic [1:0]  tlb_plv, tlb_mat;

    int errors = 0;
    int checks = 0;
    logic accepted;

    typedef struct {
        logic [31:0] pa;
        logic [1:0]  mat;
        logic        exc;
        logic [5:0]  ecode;
        logic [31:0] badv;
        logic [3:0]  idx;
        logic        chk_idx;
    } exp_t;

    exp_t sb[$];
    exp_t cur;

    always #5 clk = ~clk;

    dmmu_xlate_if #(.TLBNUM(16)) bus ();

    dmmu_xlate #(.TLBNUM(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .bus         (bus),
        .csr_da      (csr_da),
        .csr_pg      (csr_pg),
        .csr_plv     (csr_plv),
        .csr_datm    (csr_datm),
        .csr_asid    (csr_asid),
        .csr_dmw0    (csr_dmw0),
        .csr_dmw1    (csr_dmw1),
        .s1_vppn     (s1_vppn),
        .s1_va_bit12 (s1_va_bit12),
        .s1_asid     (s1_asid),
        .s1_found    (tlb_found),
        .s1_index    (tlb_index),
        .s1_ppn      (tlb_ppn),
        .s1_ps       (tlb_ps),
        .s1_plv      (tlb_plv),
        .s1_mat      (tlb_mat),
        .s1_d        (tlb_d),
        .s1_v        (tlb_v)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_exp(input logic [31:0] pa, input logic [1:0] mat, input logic exc,
                           input logic [5:0] ecode, input logic [31:0] badv,
                           input logic [3:0] idx, input logic chk_idx);
        cur.pa = pa; cur.mat = mat; cur.exc = exc; cur.ecode = ecode;
        cur.badv = badv; cur.idx = idx; cur.chk_idx = chk_idx;
    endtask

    // One clock: compare any completing response, record any accept, step the edge
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (bus.resp_valid && bus.resp_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", {31'd0, bus.resp_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("resp_pa",    bus.resp_pa,    e.pa);
                chk("resp_exc",   {31'd0, bus.resp_exc}, {31'd0, e.exc});
                chk("resp_ecode", {26'd0, bus.resp_ecode}, {26'd0, e.ecode});
                chk("resp_badv",  bus.resp_badv,  e.badv);
                if (!e.exc) chk("resp_mat", {30'd0, bus.resp_mat}, {30'd0, e.mat});
                if (e.chk_idx) chk("resp_tlb_index", {28'd0, bus.resp_tlb_index}, {28'd0, e.idx});
            end
        end
        accepted = bus.req_valid && bus.req_ready && !flush && !reset;
        if (accepted) sb.push_back(cur);
        @(posedge clk);
        #1;
        if (flush || reset) sb.delete();
    endtask

    // Present one request until accepted; returns with it sitting in S1
    task automatic issue(input logic [31:0] va, input logic wr);
        int n;
        bus.req_valid = 1'b1;
        bus.req_va    = va;
        bus.req_wr    = wr;
        n = 0;
        accepted = 1'b0;
        while (!accepted && n < 20) begin
            tick();
            n++;
        end
        chk("accept_in_time", {31'd0, accepted}, 32'd1);
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        chk("drain_empty", sb.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; flush = 1'b0;
        bus.req_valid = 1'b0; bus.req_va = 32'd0; bus.req_wr = 1'b0; bus.resp_ready = 1'b1;
        csr_da = 1'b0; csr_pg = 1'b1; csr_plv = 2'd0; csr_datm = 2'd0; csr_asid = 10'h02A;
        csr_dmw0 = 32'd0; csr_dmw1 = 32'd0;
        tlb_found = 1'b1; tlb_index = 4'd5; tlb_ppn = 20'h12345; tlb_ps = 6'd12;
        tlb_plv = 2'd3; tlb_mat = 2'd2; tlb_d = 1'b1; tlb_v = 1'b1;
        set_exp(32'd0, 2'd0, 1'b0, 6'd0, 32'd0, 4'd0, 1'b0);
        tick(); tick();
        reset = 1'b0;

        // Reset state
        chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst_req_ready",  {31'd0, bus.req_ready}, 32'd1);
        chk("rst_resp_pa",    bus.resp_pa, 32'd0);
        chk("rst_resp_ecode", {26'd0, bus.resp_ecode}, 32'd0);
        chk("rst_s1_vppn",    {13'd0, s1_vppn}, 32'd0);

        // DA mode, two-cycle latency, CSR change after accept is ignored
        csr_da = 1'b1; csr_datm = 2'd1;
        set_exp(32'h1C00_0000, 2'd1, 1'b0, 6'd0, 32'h1C00_0000, 4'd0, 1'b0);
        issue(32'h1C00_0000, 1'b0);
        csr_datm = 2'd2;
        chk("lat_cycle1_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        tick();
        chk("lat_cycle2_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
        drain();
        csr_da = 1'b0; csr_datm = 2'd0;

        // DMW0 hit at PLV0
        csr_dmw0 = 32'h8000_0011;
        set_exp(32'h0000_1234, 2'd1, 1'b0, 6'd0, 32'h8000_1234, 4'd0, 1'b0);
        issue(32'h8000_1234, 1'b0);
        drain();

        // Same request at PLV3 misses the window and goes to the TLB
        csr_plv = 2'd3;
        set_exp(32'h1234_5234, 2'd2, 1'b0, 6'd0, 32'h8000_1234, 4'd5, 1'b1);
        issue(32'h8000_1234, 1'b0);
        chk("s1_vppn",     {13'd0, s1_vppn}, 32'h0004_0000);
        chk("s1_va_bit12", {31'd0, s1_va_bit12}, 32'd1);
        chk("s1_asid",     {22'd0, s1_asid}, 32'h0000_002A);
        drain();

        // DMW1 hit at PLV3: PSEG=1, MAT=2
        csr_dmw0 = 32'h0000_0000; csr_dmw1 = 32'hA200_0028;
        set_exp(32'h2123_4567, 2'd2, 1'b0, 6'd0, 32'hA123_4567, 4'd0, 1'b0);
        issue(32'hA123_4567, 1'b0);
        drain();

        // Both windows hit: DMW0 (PSEG=0, MAT=1) takes priority
        csr_dmw0 = 32'hA000_0019;
        set_exp(32'h0123_4567, 2'd1, 1'b0, 6'd0, 32'hA123_4567, 4'd0, 1'b0);
        issue(32'hA123_4567, 1'b0);
        drain();
        csr_dmw0 = 32'd0; csr_dmw1 = 32'd0; csr_plv = 2'd0;

        // TLB 4K page
        set_exp(32'h1234_5ABC, 2'd2, 1'b0, 6'd0, 32'h0040_0ABC, 4'd5, 1'b1);
        issue(32'h0040_0ABC, 1'b0);
        drain();

        // TLB 4M page: PA = {ppn[19:9], va[20:0]} = {11'h091, 21'h054321}
        tlb_ps = 6'd21; tlb_index = 4'd9;
        set_exp(32'h1225_4321, 2'd2, 1'b0, 6'd0, 32'h0065_4321, 4'd9, 1'b1);
        issue(32'h0065_4321, 1'b1);
        drain();
        tlb_ps = 6'd12; tlb_index = 4'd5;

        // TLB refill
        tlb_found = 1'b0;
        set_exp(32'd0, 2'd0, 1'b1, 6'h3F, 32'h0070_0010, 4'd5, 1'b1);
        issue(32'h0070_0010, 1'b0);
        drain();
        tlb_found = 1'b1;

        // Invalid page: store then load
        tlb_v = 1'b0;
        set_exp(32'd0, 2'd0, 1'b1, 6'h02, 32'h0070_0020, 4'd5, 1'b1);
        issue(32'h0070_0020, 1'b1);
        drain();
        set_exp(32'd0, 2'd0, 1'b1, 6'h01, 32'h0070_0024, 4'd5, 1'b1);
        issue(32'h0070_0024, 1'b0);
        drain();
        tlb_v = 1'b1;

        // Privilege violation: PLV3 against a PLV0 page
        csr_plv = 2'd3; tlb_plv = 2'd0;
        set_exp(32'd0, 2'd0, 1'b1, 6'h07, 32'h0070_0030, 4'd5, 1'b1);
        issue(32'h0070_0030, 1'b0);
        drain();

        // Invalid and privilege violation together: PIS wins
        tlb_v = 1'b0;
        set_exp(32'd0, 2'd0, 1'b1, 6'h02, 32'h0070_0034, 4'd5, 1'b1);
        issue(32'h0070_0034, 1'b1);
        drain();
        tlb_v = 1'b1; csr_plv = 2'd0; tlb_plv = 2'd3;

        // Store to a clean page
        tlb_d = 1'b0;
        set_exp(32'd0, 2'd0, 1'b1, 6'h04, 32'h0070_0040, 4'd5, 1'b1);
        issue(32'h0070_0040, 1'b1);
        drain();
        tlb_d = 1'b1;

        // Backpressure: four back-to-back requests through DMW0, consumer stalls 3 cycles
        csr_dmw0 = 32'h8000_0011;
        bus.resp_ready = 1'b0;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.req_va = 32'h8000_0040 + 32'(i) * 32'h100;
            set_exp(32'h0000_0040 + 32'(i) * 32'h100, 2'd1, 1'b0, 6'd0, bus.req_va, 4'd0, 1'b0);
            tick();
            chk("bp_accept", {31'd0, accepted}, 32'd1);
        end
        chk("bp_req_ready_low", {31'd0, bus.req_ready}, 32'd0);
        chk("bp_resp_valid",    {31'd0, bus.resp_valid}, 32'd1);
        chk("bp_hold_pa_a",     bus.resp_pa, 32'h0000_0040);
        bus.req_va = 32'h8000_0240;
        set_exp(32'h0000_0240, 2'd1, 1'b0, 6'd0, 32'h8000_0240, 4'd0, 1'b0);
        tick();
        chk("bp_no_accept",     {31'd0, accepted}, 32'd0);
        chk("bp_hold_pa_b",     bus.resp_pa, 32'h0000_0040);
        chk("bp_hold_badv",     bus.resp_badv, 32'h8000_0040);
        bus.resp_ready = 1'b1;
        issue(32'h8000_0240, 1'b0);
        set_exp(32'h0000_0340, 2'd1, 1'b0, 6'd0, 32'h8000_0340, 4'd0, 1'b0);
        issue(32'h8000_0340, 1'b0);
        drain();

        // Flush with S1 and S2 both occupied; the flush-cycle request is dropped
        bus.resp_ready = 1'b0;
        set_exp(32'h0000_0500, 2'd1, 1'b0, 6'd0, 32'h8000_0500, 4'd0, 1'b0);
        issue(32'h8000_0500, 1'b0);
        set_exp(32'h0000_0600, 2'd1, 1'b0, 6'd0, 32'h8000_0600, 4'd0, 1'b0);
        issue(32'h8000_0600, 1'b0);
        chk("fl_pre_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
        flush = 1'b1; bus.req_valid = 1'b1; bus.req_va = 32'h8000_0700;
        tick();
        flush = 1'b0; bus.req_valid = 1'b0;
        chk("fl_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("fl_req_ready",  {31'd0, bus.req_ready}, 32'd1);
        chk("fl_s1_vppn",    {13'd0, s1_vppn}, 32'd0);
        bus.resp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fl_no_stale", {31'd0, bus.resp_valid}, 32'd0);
        end

        // Reset mid-stream
        bus.resp_ready = 1'b0;
        issue(32'h8000_0800, 1'b0);
        issue(32'h8000_0900, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rs_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rs_req_ready",  {31'd0, bus.req_ready}, 32'd1);
        chk("rs_resp_pa",    bus.resp_pa, 32'd0);
        chk("rs_resp_badv",  bus.resp_badv, 32'd0);
        bus.resp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rs_no_stale", {31'd0, bus.resp_valid}, 32'd0);
        end

        // Traffic resumes normally after the reset
        set_exp(32'h0000_0A00, 2'd1, 1'b0, 6'd0, 32'h8000_0A00, 4'd0, 1'b0);
        issue(32'h8000_0A00, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
